// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage register: one packet plus NUM_WORDS operand words,
// valid/ready handshake with a 2-entry skid buffer and synchronous flush.
module pipe_stage_buf #(
    parameter int WIDTH     = 16,
    parameter int NUM_WORDS = 3,
    parameter int PKT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PKT_WIDTH-1:0]       in_ipacket,
    input  logic [NUM_WORDS*WIDTH-1:0] in_words,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PKT_WIDTH-1:0]       out_ipacket,
    output logic [NUM_WORDS*WIDTH-1:0] out_words,
    output logic [1:0]                 occupancy
);

    localparam int DW = NUM_WORDS * WIDTH;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PKT_WIDTH-1:0] main_pkt_q, main_pkt_d;
    logic [PKT_WIDTH-1:0] skid_pkt_q, skid_pkt_d;
    logic [DW-1:0]        main_words_q, main_words_d;
    logic [DW-1:0]        skid_words_q, skid_words_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [1:0]           occ_q, occ_d;
    logic                 accept_s;
    logic                 emit_s;

    assign accept_s = in_valid & in_ready_q;
    assign emit_s   = out_valid_q & out_ready;

    // Next-state and payload selection; handshake flags are decoded from the next state
    always_comb begin
        state_d      = state_q;
        main_pkt_d   = main_pkt_q;
        main_words_d = main_words_q;
        skid_pkt_d   = skid_pkt_q;
        skid_words_d = skid_words_q;
        if (flush) begin
            state_d      = ST_EMPTY;
            main_pkt_d   = {PKT_WIDTH{1'b0}};
            main_words_d = {DW{1'b0}};
            skid_pkt_d   = {PKT_WIDTH{1'b0}};
            skid_words_d = {DW{1'b0}};
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_pkt_d   = in_ipacket;
                        main_words_d = in_words;
                        state_d      = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && emit_s) begin
                        main_pkt_d   = in_ipacket;
                        main_words_d = in_words;
                        state_d      = ST_ONE;
                    end else if (accept_s) begin
                        skid_pkt_d   = in_ipacket;
                        skid_words_d = in_words;
                        state_d      = ST_TWO;
                    end else if (emit_s) begin
                        // Main keeps the last emitted value after a plain drain
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (emit_s) begin
                        main_pkt_d   = skid_pkt_q;
                        main_words_d = skid_words_q;
                        state_d      = ST_ONE;
                    end else begin
                        state_d = ST_TWO;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        case (state_d)
            ST_EMPTY: begin in_ready_d = 1'b1; out_valid_d = 1'b0; occ_d = 2'd0; end
            ST_ONE:   begin in_ready_d = 1'b1; out_valid_d = 1'b1; occ_d = 2'd1; end
            ST_TWO:   begin in_ready_d = 1'b0; out_valid_d = 1'b1; occ_d = 2'd2; end
            default:  begin in_ready_d = 1'b1; out_valid_d = 1'b0; occ_d = 2'd0; end
        endcase
    end

    // State, payload and registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            main_pkt_q   <= {PKT_WIDTH{1'b0}};
            main_words_q <= {DW{1'b0}};
            skid_pkt_q   <= {PKT_WIDTH{1'b0}};
            skid_words_q <= {DW{1'b0}};
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            occ_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            main_pkt_q   <= main_pkt_d;
            main_words_q <= main_words_d;
            skid_pkt_q   <= skid_pkt_d;
            skid_words_q <= skid_words_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            occ_q        <= occ_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_ipacket = main_pkt_q;
    assign out_words   = main_words_q;
    assign occupancy   = occ_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: two instances (default and wide parameter sets)
// share control and are checked against a queue-based reference model.
module tb_pipe_stage_buf;

    localparam int AW = 16, AN = 3, AP = 32;
    localparam int BW = 32, BN = 5, BP = 8;

    logic clk = 1'b0, clk_en = 1'b0, rst_n = 1'b1;
    logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;

    logic [AP-1:0]    a_in_pkt = '0, a_out_pkt;
    logic [AN*AW-1:0] a_in_w = '0, a_out_w;
    logic             a_in_ready, a_out_valid;
    logic [1:0]       a_occ;

    logic [BP-1:0]    b_in_pkt = '0, b_out_pkt;
    logic [BN*BW-1:0] b_in_w = '0, b_out_w;
    logic             b_in_ready, b_out_valid;
    logic [1:0]       b_occ;

    pipe_stage_buf #(.WIDTH(AW), .NUM_WORDS(AN), .PKT_WIDTH(AP)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ipacket(a_in_pkt), .in_words(a_in_w),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_ipacket(a_out_pkt), .out_words(a_out_w), .occupancy(a_occ)
    );

    pipe_stage_buf #(.WIDTH(BW), .NUM_WORDS(BN), .PKT_WIDTH(BP)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ipacket(b_in_pkt), .in_words(b_in_w),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_ipacket(b_out_pkt), .out_words(b_out_w), .occupancy(b_occ)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    typedef struct {
        logic [AP-1:0]    ap;
        logic [AN*AW-1:0] aw;
        logic [BP-1:0]    bp;
        logic [BN*BW-1:0] bw;
    } ent_t;

    ent_t q[$];
    ent_t last;
    ent_t zero_e;
    int   total = 0;
    int   bad = 0;
    bit   took;

    task automatic chk(string tag, logic [159:0] obs, logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int   n;
        ent_t e;
        n = q.size();
        e = (n > 0) ? q[0] : last;
        chk("a_out_valid", 160'(a_out_valid), 160'(n > 0));
        chk("a_in_ready",  160'(a_in_ready),  160'(n < 2));
        chk("a_occupancy", 160'(a_occ),       160'(n));
        chk("a_out_ipacket", 160'(a_out_pkt), 160'(e.ap));
        chk("a_out_words",   160'(a_out_w),   160'(e.aw));
        chk("b_out_valid", 160'(b_out_valid), 160'(n > 0));
        chk("b_in_ready",  160'(b_in_ready),  160'(n < 2));
        chk("b_occupancy", 160'(b_occ),       160'(n));
        chk("b_out_ipacket", 160'(b_out_pkt), 160'(e.bp));
        chk("b_out_words",   160'(b_out_w),   160'(e.bw));
        chk("b_top_slice", 160'(b_out_w[4*BW +: BW]), 160'(e.bw[4*BW +: BW]));
    endtask

    task automatic offer(logic [AP-1:0] ap, logic [AN*AW-1:0] aw);
        a_in_pkt = ap;
        a_in_w   = aw;
        b_in_pkt = BP'($urandom);
        b_in_w   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // One clock: update the model from the rules, then compare just after the edge
    task automatic cycle();
        bit   acc, emt;
        ent_t cur;
        @(posedge clk);
        cur.ap = a_in_pkt; cur.aw = a_in_w; cur.bp = b_in_pkt; cur.bw = b_in_w;
        acc = in_valid && (q.size() < 2) && !flush;
        emt = (q.size() > 0) && out_ready;
        if (flush) begin
            q.delete();
            last = zero_e;
            took = 1'b0;
        end else begin
            if (emt) last = q.pop_front();
            if (acc) q.push_back(cur);
            took = acc;
        end
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic send(logic [AP-1:0] ap, logic [AN*AW-1:0] aw);
        int budget;
        budget = 20;
        in_valid = 1'b1;
        offer(ap, aw);
        cycle();
        while (!took && budget > 0) begin
            cycle();
            budget--;
        end
        if (!took) begin
            total++;
            bad++;
            $error("FAIL send_timeout observed=%0h expected=accepted", ap);
        end
    endtask

    initial begin
        logic [15:0] w;
        zero_e.ap = '0; zero_e.aw = '0; zero_e.bp = '0; zero_e.bw = '0;
        last = zero_e;

        // Reset with the clock stopped
        #2 rst_n = 1'b0;
        #1 check_all();
        #3 clk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back streaming P1..P8
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            w = 16'(16'h1111 * i);
            send(AP'(i), {w, w, w});
        end
        in_valid = 1'b0;
        cycle();
        cycle();

        // Stall for three cycles while P3 is on the output
        send(32'h31, {16'h3101, 16'h3102, 16'h3103});
        send(32'h32, {16'h3201, 16'h3202, 16'h3203});
        send(32'h33, {16'h3301, 16'h3302, 16'h3303});
        out_ready = 1'b0;
        offer(32'h34, {16'h3401, 16'h3402, 16'h3403});
        cycle();
        offer(32'h35, {16'h3501, 16'h3502, 16'h3503});
        cycle();
        cycle();
        chk("stall_occupancy", 160'(a_occ), 160'(2));
        chk("stall_in_ready", 160'(a_in_ready), 160'(0));
        out_ready = 1'b1;
        cycle();
        chk("resume_first_out", 160'(a_out_pkt), 160'(32'h34));
        send(32'h35, {16'h3501, 16'h3502, 16'h3503});
        in_valid = 1'b0;
        cycle();
        cycle();

        // Flush while full, with P9 offered in the flush cycle
        out_ready = 1'b0;
        send(32'h41, {16'h4101, 16'h4102, 16'h4103});
        send(32'h42, {16'h4201, 16'h4202, 16'h4203});
        chk("full_before_flush", 160'(a_occ), 160'(2));
        flush = 1'b1;
        in_valid = 1'b1;
        offer(32'h99, {16'h9901, 16'h9902, 16'h9903});
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_ipacket_zero", 160'(a_out_pkt), 160'(0));
        out_ready = 1'b1;
        cycle();
        cycle();

        // Simultaneous accept and emit in ONE
        out_ready = 1'b0;
        send(32'hA, {16'h0A02, 16'h0A01, 16'hAAAA});
        out_ready = 1'b1;
        send(32'hB, {16'h0B02, 16'h0B01, 16'hBBBB});
        chk("simul_word0", 160'(a_out_w[15:0]), 160'(16'hBBBB));
        chk("simul_occupancy", 160'(a_occ), 160'(1));
        in_valid = 1'b0;
        cycle();

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 15) == 0);
            offer($urandom, {16'($urandom), 16'($urandom), 16'($urandom)});
            cycle();
        end
        flush = 1'b0;

        // Asynchronous reset while holding two entries
        out_ready = 1'b1;
        in_valid = 1'b0;
        cycle();
        cycle();
        out_ready = 1'b0;
        send(32'h51, {16'h5101, 16'h5102, 16'h5103});
        send(32'h52, {16'h5201, 16'h5202, 16'h5203});
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        last = zero_e;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(32'h61, {16'h6101, 16'h6102, 16'h6103});
        in_valid = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
